apple_eat_ctrl: RTL
===================

# apple_eat_ctrl

Consumer side of the apple coordinate stream. Samples the free-running apple position generator's `newapple_x/newapple_y`, validates the candidate against the game grid and the snake body occupancy store, then holds it as the live apple. On each game tick it checks the snake head against the live apple and, on a hit, pulses `eaten`, bumps the score and fetches a replacement. Sits between the apple generator, the snake body store and the renderer/score display.

## Interface

- `MAX_RETRY`, 8: candidates rejected in a row before forced placement (1..255).
- `SCORE_W`, 16: score counter width.
- `clk` in 1: system clock, all logic on rising edge.
- `btnrst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle game-step strobe.
- `snakehead_x` in 11: head pixel-centre X.
- `snakehead_y` in 11: head pixel-centre Y.
- `newapple_x` in 11: candidate X from generator (changes every cycle).
- `newapple_y` in 11: candidate Y from generator.
- `occ_req` out 1: occupancy query request to body store.
- `occ_x`, `occ_y` out 11 each: coordinates being queried, stable while `occ_req`=1.
- `occ_ack` in 1: body store response valid, 1 cycle.
- `occ_hit` in 1: cell occupied by body, valid with `occ_ack`.
- `apple_x`, `apple_y` out 11 each: live apple position.
- `apple_valid` out 1: live apple displayed/eatable.
- `eaten` out 1: one-cycle pulse, apple consumed.
- `place_fail` out 1: one-cycle pulse, forced placement after `MAX_RETRY` rejects.
- `score` out `SCORE_W`: apples eaten, saturating.

## Operation

- States: SAMPLE, QUERY, ACTIVE.
- Reset (async, `btnrst_n`=0): state SAMPLE, `apple_x`=16, `apple_y`=144, `apple_valid`=0, `occ_req`=0, `occ_x`/`occ_y`=0, `eaten`=0, `place_fail`=0, `score`=0, retry count 0. Outputs drop in the same instant as reset assertion, including mid-query.
- SAMPLE (1 cycle): register `newapple_x/y` into candidate. Grid check: x in 16..1392, y in 144..848, and low 5 bits of both == 16.
  - Fails grid check: retry++, stay SAMPLE.
  - Passes: drive `occ_x/occ_y` = candidate, `occ_req`=1, go QUERY.
- QUERY: hold `occ_req`, `occ_x`, `occ_y` until `occ_ack`. On ack, `occ_req`=0 the next cycle.
  - `occ_hit`=0: load `apple_x/y` from candidate, `apple_valid`=1, retry=0, go ACTIVE.
  - `occ_hit`=1: retry++, go SAMPLE.
- Retry exhaustion: when a reject brings retry to `MAX_RETRY`, the next candidate that passes the grid check is accepted without a query. `place_fail` pulses on that load. Retry is cleared.
- ACTIVE: on `tick` with `snakehead_x`==`apple_x` and `snakehead_y`==`apple_y`:
  - `eaten`=1 for one cycle, `apple_valid`=0.
  - `score`+1, saturating at all-ones.
  - Go SAMPLE. `apple_x/y` keep the old value until the replacement loads.
- `tick` in SAMPLE/QUERY is ignored. There is no eat without `apple_valid`.
- Comparisons are exact 11-bit equality. No arithmetic on coordinates.

## Timing

- `eaten` and `apple_valid` fall are registered: one cycle after the `tick` edge.
- Best-case replacement, eaten to `apple_valid`=1: SAMPLE 1 cycle + `occ_req` issue 1 cycle + ack latency L + load 1 cycle.
- With a 1-cycle store, `apple_valid` rises 4 cycles after `eaten`.
- `occ_ack` arriving outside QUERY is ignored.
- `occ_ack` may arrive the same cycle `occ_req` rises only if the store is combinational. It is sampled on the next edge regardless.
- `score` updates in the same cycle as `eaten`.

## Structure

- Shared package `snake_pkg` holds:
  - `COORD_W`=11, `CELL`=32, `X_MIN`=16, `X_MAX`=1392, `Y_MIN`=144, `Y_MAX`=848.
  - The state enum (SAMPLE/QUERY/ACTIVE).
- Sub-module `apple_cand_check`: combinational grid/alignment check on candidate x,y returning ok. The generator bench reuses it.

## Test plan

- Reset release, generator gives (48,176), store acks 1 cycle later with `occ_hit`=0 -> `apple_x/y`=(48,176), `apple_valid`=1 within 4 cycles, `score`=0.
- Live apple (48,176), `tick` with head (48,176) -> `eaten` pulse next cycle, `score`=1, `apple_valid`=0, new query issued.
- `tick` with head (80,176) -> no `eaten`, `score` unchanged.
- `occ_hit`=1 for 8 consecutive queries, `MAX_RETRY`=8 -> next aligned candidate loaded with no `occ_req`, `place_fail` pulses once.
- Candidate (20,144), misaligned -> no `occ_req`, resample next cycle.
- Candidate (1424,144), out of range -> no `occ_req`, resample next cycle.
- Assert `btnrst_n` low while `occ_req`=1 -> `occ_req` drops immediately, all outputs at reset values, late `occ_ack` ignored.
- `score` preloaded to 0xFFFF via repeated eats -> further eat keeps 0xFFFF and `eaten` still pulses.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game constants, coordinate type and apple-controller state encoding.
package snake_pkg;
    localparam int COORD_W = 11;
    localparam int CELL    = 32;
    localparam int X_MIN   = 16;
    localparam int X_MAX   = 1392;
    localparam int Y_MIN   = 144;
    localparam int Y_MAX   = 848;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        QUERY  = 2'd1,
        ACTIVE = 2'd2
    } apple_state_e;

    // A coordinate is a legal cell centre when its offset inside the cell is CELL/2.
    function automatic logic cell_centred(input coord_t c);
        return (c & coord_t'(CELL - 1)) == coord_t'(CELL / 2);
    endfunction
endpackage

// File: rtl/apple_cand_check.sv
// Combinational grid-range and cell-centre check on an apple candidate position.
module apple_cand_check
    import snake_pkg::*;
(
    input  coord_t x_i,
    input  coord_t y_i,
    output logic   ok_o
);
    logic x_in_range, y_in_range;

    assign x_in_range = (x_i >= coord_t'(X_MIN)) && (x_i <= coord_t'(X_MAX));
    assign y_in_range = (y_i >= coord_t'(Y_MIN)) && (y_i <= coord_t'(Y_MAX));
    assign ok_o       = x_in_range && y_in_range && cell_centred(x_i) && cell_centred(y_i);
endmodule

// File: rtl/apple_eat_ctrl.sv
// Apple placement and eat detection: validates generator candidates against the grid and the
// snake body store, holds the live apple, and scores hits of the snake head on game ticks.
module apple_eat_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_RETRY = 8,
    parameter int SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               btnrst_n,
    input  logic               tick,
    input  coord_t             snakehead_x,
    input  coord_t             snakehead_y,
    input  coord_t             newapple_x,
    input  coord_t             newapple_y,
    output logic               occ_req,
    output coord_t             occ_x,
    output coord_t             occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output coord_t             apple_x,
    output coord_t             apple_y,
    output logic               apple_valid,
    output logic               eaten,
    output logic               place_fail,
    output logic [SCORE_W-1:0] score
);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    apple_state_e       state_q, state_d;
    coord_t             cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    coord_t             apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic               occ_req_q, occ_req_d;
    logic               valid_q, valid_d;
    logic               eaten_q, eaten_d;
    logic               pfail_q, pfail_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         retry_q, retry_d, retry_inc;
    logic               cand_ok, head_hit;

    apple_cand_check u_check (
        .x_i  (newapple_x),
        .y_i  (newapple_y),
        .ok_o (cand_ok)
    );

    assign head_hit  = (snakehead_x == apple_x_q) && (snakehead_y == apple_y_q);
    // Saturates at the limit so the counter never wraps for small MAX_RETRY widths.
    assign retry_inc = (retry_q >= RETRY_LIM) ? retry_q : retry_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        apple_x_d = apple_x_q;
        apple_y_d = apple_y_q;
        occ_req_d = occ_req_q;
        valid_d   = valid_q;
        eaten_d   = 1'b0;
        pfail_d   = 1'b0;
        score_d   = score_q;
        retry_d   = retry_q;
        case (state_q)
            SAMPLE: begin
                cand_x_d = newapple_x;
                cand_y_d = newapple_y;
                if (!cand_ok) begin
                    retry_d = retry_inc;
                end else if (retry_q >= RETRY_LIM) begin
                    // Too many rejects: place without asking the body store.
                    apple_x_d = newapple_x;
                    apple_y_d = newapple_y;
                    valid_d   = 1'b1;
                    pfail_d   = 1'b1;
                    retry_d   = '0;
                    state_d   = ACTIVE;
                end else begin
                    occ_req_d = 1'b1;
                    state_d   = QUERY;
                end
            end
            QUERY: begin
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (occ_hit) begin
                        retry_d = retry_inc;
                        state_d = SAMPLE;
                    end else begin
                        apple_x_d = cand_x_q;
                        apple_y_d = cand_y_q;
                        valid_d   = 1'b1;
                        retry_d   = '0;
                        state_d   = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (tick && head_hit) begin
                    eaten_d = 1'b1;
                    valid_d = 1'b0;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                    state_d = SAMPLE;
                end
            end
            default: state_d = SAMPLE;
        endcase
    end

    always_ff @(posedge clk or negedge btnrst_n) begin
        if (!btnrst_n) begin
            state_q   <= SAMPLE;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            apple_x_q <= coord_t'(X_MIN);
            apple_y_q <= coord_t'(Y_MIN);
            occ_req_q <= 1'b0;
            valid_q   <= 1'b0;
            eaten_q   <= 1'b0;
            pfail_q   <= 1'b0;
            score_q   <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            apple_x_q <= apple_x_d;
            apple_y_q <= apple_y_d;
            occ_req_q <= occ_req_d;
            valid_q   <= valid_d;
            eaten_q   <= eaten_d;
            pfail_q   <= pfail_d;
            score_q   <= score_d;
            retry_q   <= retry_d;
        end
    end

    // The query address is the candidate register; it only moves while in SAMPLE.
    assign occ_req     = occ_req_q;
    assign occ_x       = cand_x_q;
    assign occ_y       = cand_y_q;
    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
    assign apple_valid = valid_q;
    assign eaten       = eaten_q;
    assign place_fail  = pfail_q;
    assign score       = score_q;
endmodule
